// File: rtl/seg7_scan_mux.sv
// Time-multiplexed hex driver for a common-anode seven-segment display.
// A load-only shadow keeps the shown value tear-free; one digit per refresh slot.
module seg7_scan_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            dout,
  output logic                  dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]   shadow_en_q, shadow_en_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic                blank_win;
  logic [DIGITS-1:0]   sup_vec;
  logic                upper_zero;
  logic [3:0]          cur_nib;
  logic                visible;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    hex_seg = 7'b0000000;
    case (n)
      4'h0: hex_seg = 7'b0111111;
      4'h1: hex_seg = 7'b0000110;
      4'h2: hex_seg = 7'b1011011;
      4'h3: hex_seg = 7'b1001111;
      4'h4: hex_seg = 7'b1100110;
      4'h5: hex_seg = 7'b1101101;
      4'h6: hex_seg = 7'b1111101;
      4'h7: hex_seg = 7'b0000111;
      4'h8: hex_seg = 7'b1111111;
      4'h9: hex_seg = 7'b1101111;
      4'hA: hex_seg = 7'b1110111;
      4'hB: hex_seg = 7'b1111100;
      4'hC: hex_seg = 7'b0111001;
      4'hD: hex_seg = 7'b1011110;
      4'hE: hex_seg = 7'b1111001;
      4'hF: hex_seg = 7'b1110001;
      default: hex_seg = 7'b0000000;
    endcase
  endfunction

  // Anti-ghosting window: all anodes off for the first BLANK_CYC cycles of a slot.
  generate
    if (BLANK_CYC > 0) begin : g_blank
      assign blank_win = (cnt_q < CNT_W'(BLANK_CYC));
    end else begin : g_noblank
      assign blank_win = 1'b0;
    end
  endgenerate

  // A digit is suppressed when it and every more-significant nibble are zero.
  always_comb begin
    sup_vec    = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (shadow_val_q[4*i +: 4] == 4'h0);
      sup_vec[i] = lz_blank & upper_zero;
    end
  end

  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_en_d  = shadow_en_q;
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;

    if (load) begin
      shadow_val_d = din;
      shadow_dp_d  = dp_in;
      shadow_en_d  = digit_en;
    end

    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    cur_nib = shadow_val_q[4*int'(idx_q) +: 4];
    visible = shadow_en_q[idx_q] & ~blank_win & ~sup_vec[idx_q];

    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (visible) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = ~hex_seg(cur_nib);
      dp_d  = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      shadow_en_q  <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_en_q  <= shadow_en_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an   = an_q;
  assign dout = seg_q;
  assign dp   = dp_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1.
// Each 4-cycle slot shows one blank cycle followed by three digit cycles.
module tb_seg7_scan_mux;

  localparam logic [11:0] BLANK = 12'hFFF;  // {an, dp, dout} with everything off

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  dout;
  logic        dp;

  int total = 0;
  int bad   = 0;

  seg7_scan_mux #(
    .DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .digit_en(digit_en),
    .lz_blank(lz_blank), .load(load), .an(an), .dout(dout), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got an/dp/dout=%h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] vis(input int i, input logic [3:0] nib, input logic dp_on);
    logic [3:0] one;
    one = 4'b0001;
    return {~(one << i), ~dp_on, ~SEG_TAB[nib]};
  endfunction

  // One slot starting at the edge where the pre-edge count is 0. A load pulse set
  // before the call is taken on the first edge; load_last pulses on the wrap edge.
  task automatic check_slot(input string tag, input logic [11:0] exp_on, input bit load_last);
    tick();
    check({tag, "_blank"}, {an, dp, dout}, BLANK);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (load_last && k == 2) load = 1'b1;
      tick();
      check(tag, {an, dp, dout}, exp_on);
    end
    load = 1'b0;
  endtask

  initial begin
    // Reset held three cycles
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst", {an, dp, dout}, BLANK);
    end

    // Scan order
    rst = 1'b0; din = 16'h1234; digit_en = 4'hF; load = 1'b1;
    check_slot("scan_d0", vis(0, 4'h4, 1'b0), 1'b0);
    check_slot("scan_d1", vis(1, 4'h3, 1'b0), 1'b0);
    check_slot("scan_d2", vis(2, 4'h2, 1'b0), 1'b0);
    check_slot("scan_d3", vis(3, 4'h1, 1'b0), 1'b0);
    check_slot("scan_wrap_d0", vis(0, 4'h4, 1'b0), 1'b0);
    check_slot("scan_d1b", vis(1, 4'h3, 1'b0), 1'b0);
    check_slot("scan_d2b", vis(2, 4'h2, 1'b0), 1'b0);
    check_slot("scan_d3b", vis(3, 4'h1, 1'b0), 1'b0);

    // Full hex table on digit 0 only
    for (int v = 0; v < 16; v++) begin
      din = 16'(v); digit_en = 4'b0001; load = 1'b1;
      check_slot($sformatf("hex_%0h", v), vis(0, 4'(v), 1'b0), 1'b0);
      check_slot("hex_off1", BLANK, 1'b0);
      check_slot("hex_off2", BLANK, 1'b0);
      check_slot("hex_off3", BLANK, 1'b0);
    end

    // Leading-zero suppression
    din = 16'h0040; digit_en = 4'hF; lz_blank = 1'b1; load = 1'b1;
    check_slot("lz_d0", vis(0, 4'h0, 1'b0), 1'b0);
    check_slot("lz_d1", vis(1, 4'h4, 1'b0), 1'b0);
    check_slot("lz_d2_sup", BLANK, 1'b0);
    check_slot("lz_d3_sup", BLANK, 1'b0);
    lz_blank = 1'b0;
    check_slot("nolz_d0", vis(0, 4'h0, 1'b0), 1'b0);
    check_slot("nolz_d1", vis(1, 4'h4, 1'b0), 1'b0);
    check_slot("nolz_d2", vis(2, 4'h0, 1'b0), 1'b0);
    check_slot("nolz_d3", vis(3, 4'h0, 1'b0), 1'b0);

    // Decimal point on a disabled digit, then with all enabled
    din = 16'h8888; dp_in = 4'b0100; digit_en = 4'b1011; load = 1'b1;
    check_slot("dpen_d0", vis(0, 4'h8, 1'b0), 1'b0);
    check_slot("dpen_d1", vis(1, 4'h8, 1'b0), 1'b0);
    check_slot("dpen_d2_off", BLANK, 1'b0);
    check_slot("dpen_d3", vis(3, 4'h8, 1'b0), 1'b0);
    digit_en = 4'hF; load = 1'b1;
    check_slot("dp_d0", vis(0, 4'h8, 1'b0), 1'b0);
    check_slot("dp_d1", vis(1, 4'h8, 1'b0), 1'b0);
    check_slot("dp_d2", vis(2, 4'h8, 1'b1), 1'b0);
    check_slot("dp_d3", vis(3, 4'h8, 1'b0), 1'b0);

    // Tear-free: din changes without load, then load on the wrap edge into digit 0
    din = 16'hABCD;
    check_slot("tear_d0", vis(0, 4'h8, 1'b0), 1'b0);
    check_slot("tear_d1", vis(1, 4'h8, 1'b0), 1'b0);
    check_slot("tear_d2", vis(2, 4'h8, 1'b1), 1'b0);
    check_slot("tear_d3", vis(3, 4'h8, 1'b0), 1'b1);
    check_slot("newval_d0", vis(0, 4'hD, 1'b0), 1'b0);
    check_slot("newval_d1", vis(1, 4'hC, 1'b0), 1'b0);

    // Mid-scan reset while digit 2 is visible
    tick();
    check("mid_d2_blank", {an, dp, dout}, BLANK);
    tick();
    check("mid_d2_vis", {an, dp, dout}, vis(2, 4'hB, 1'b1));
    rst = 1'b1;
    tick();
    check("mid_rst", {an, dp, dout}, BLANK);
    rst = 1'b0;
    check_slot("post_rst_d0", BLANK, 1'b0);
    check_slot("post_rst_d1", BLANK, 1'b0);
    check_slot("post_rst_d2", BLANK, 1'b0);
    check_slot("post_rst_d3", BLANK, 1'b0);
    din = 16'h1234; dp_in = 4'b0001; digit_en = 4'hF; load = 1'b1;
    check_slot("reload_d0", vis(0, 4'h4, 1'b1), 1'b0);
    check_slot("reload_d1", vis(1, 4'h3, 1'b0), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
